alu_pkt_rx: RTL
===============

ALU_PKT_RX -- requirements
Module: alu_pkt_rx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, UART byte width; operand word is 4*DATA_WIDTH.
REQ-002 SHALL have port clk_i  input  1  single clock, all logic on rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset; one clock, reset synchronous and active-low.
REQ-004 SHALL have ports rx_data_i input DATA_WIDTH, rx_valid_i input 1, rx_ready_o output 1: byte stream from UART receiver.
REQ-005 SHALL have ports word_o output 4*DATA_WIDTH, word_valid_o output 1, word_ready_i input 1: little-endian operand words to arithmetic stage.
REQ-006 SHALL have ports op_o output 2 (0 ADD, 1 MUL, 2 DIV), word_first_o output 1, word_last_o output 1: qualifiers valid with word_valid_o.
REQ-007 SHALL have ports echo_data_o output DATA_WIDTH, echo_valid_o output 1, echo_ready_i input 1: echo byte stream to UART transmitter.
REQ-008 SHALL have port err_o output 1: one-cycle pulse per rejected packet.

Function
REQ-009 SHALL parse packet: opcode byte, reserved byte, length LSB, length MSB, payload; length = total bytes including 4-byte header.
REQ-010 SHALL decode opcodes 0xEC ECHO, 0xAD ADD, 0x88 MUL, 0xD1 DIV; any other value is invalid.
REQ-011 SHALL implement states OPCODE, RESERVED, LEN_LSB, LEN_MSB, ECHO, COLLECT, EMIT, DISCARD.
REQ-012 SHALL assert rx_ready_o=1 in OPCODE, RESERVED, LEN_LSB, LEN_MSB, COLLECT, DISCARD; 0 in EMIT.
REQ-013 SHALL advance header states one per accepted byte (rx_valid_i && rx_ready_o); no advance without handshake.
REQ-014 SHALL at LEN_MSB compute payload count = length-4, latched in 16-bit down-counter; length < 4 -> err_o pulse, return to OPCODE.
REQ-015 SHALL at LEN_MSB go ECHO for echo opcode, COLLECT for ADD/MUL/DIV, DISCARD for invalid opcode (err_o pulse); payload 0 -> OPCODE.
REQ-016 SHALL in ECHO drive echo_data_o=rx_data_i, echo_valid_o=rx_valid_i, rx_ready_o=echo_ready_i combinationally; decrement count per handshake; OPCODE after last byte.
REQ-017 SHALL in COLLECT place byte k (0..3) at word bits [8k+7:8k]; after 4th byte go EMIT.
REQ-018 SHALL in EMIT hold word_valid_o=1 and word_o, op_o, word_first_o, word_last_o stable until word_ready_i; on handshake go COLLECT, or OPCODE if count==0.
REQ-019 SHALL set word_first_o=1 for first word of packet only; word_last_o=1 when remaining count==0.
REQ-020 SHALL in DISCARD accept and drop bytes until count==0, then OPCODE.
REQ-021 SHALL deassert word_valid_o and echo_valid_o in all states other than EMIT and ECHO respectively.
REQ-022 SHALL accept a new opcode byte the cycle after final payload handshake; minimum word latency: word_valid_o one cycle after 4th byte handshake.

Reset
REQ-023 SHALL on rst_ni=0 at clock edge go OPCODE, clear counters, word register, first flag; word_valid_o=0, echo_valid_o=0, err_o=0, rx_ready_o=1 next cycle.
REQ-024 SHALL on reset mid-packet drop partial word and remaining payload; following bytes parsed as new opcode.

Configuration
REQ-025 SHALL with macro ALU_PKT_RX_CHKLEN_EN defined reject at LEN_MSB any ADD/MUL/DIV packet whose payload is not a multiple of 4 or < 8: err_o pulse, DISCARD.
REQ-026 SHALL without ALU_PKT_RX_CHKLEN_EN accept any payload; trailing 1-3 bytes of final partial word dropped silently, last complete word flagged word_last_o; payload < 4 emits no word.

Verification
REQ-027 SHALL test ADD: bytes AD 00 0C 00, 01 00 00 00, 02 00 00 00 -> words 0x00000001 (first) then 0x00000002 (last), op_o=0.
REQ-028 SHALL test ECHO with echo_ready_i toggling every cycle: EC 00 07 00 41 42 43 -> echo bytes 41 42 43 in order, no byte lost or duplicated.
REQ-029 SHALL test invalid opcode: 55 00 08 00 + 4 bytes -> err_o one pulse, no word, next packet AD 00 0C 00... parsed normally.
REQ-030 SHALL test backpressure: word_ready_i=0 for 10 cycles in EMIT -> word_o stable, rx_ready_o=0, no byte consumed.
REQ-031 SHALL test rst_ni=0 after 2 payload bytes of MUL packet -> no word output; subsequent 88 00 0C 00 ... packet yields correct two words.
REQ-032 SHALL test length 0x000A MUL with ALU_PKT_RX_CHKLEN_EN -> err_o pulse, 6 bytes discarded; without macro -> one word (last), 2 bytes dropped.

Source files
------------

// File: rtl/alu_pkt_rx.sv
// alu_pkt_rx -- packet parser between a UART byte receiver and an arithmetic stage.
//
// Packet layout: opcode, reserved, length LSB, length MSB, payload. The length
// counts the whole packet, including the 4-byte header.
//   0xEC ECHO : payload bytes are forwarded to the echo stream.
//   0xAD ADD, 0x88 MUL, 0xD1 DIV : each group of 4 payload bytes is packed
//     little-endian into one operand word.
//   Anything else is rejected: err_o pulses and the payload is dropped.
//
// Ports
//   clk_i, rst_ni           clock; synchronous active-low reset
//   rx_data_i/valid/ready   byte stream from the UART receiver
//   word_o/valid/ready      operand words (4*DATA_WIDTH) to the arithmetic stage
//   op_o                    0 ADD, 1 MUL, 2 DIV (qualified by word_valid_o)
//   word_first_o/last_o     first / last word of the packet (qualified by word_valid_o)
//   echo_data_o/valid/ready echo byte stream to the UART transmitter
//   err_o                   one-cycle pulse for each rejected packet
//
// Build option: defining ALU_PKT_RX_CHKLEN_EN rejects any ADD/MUL/DIV packet
// whose payload is not a multiple of 4 or is shorter than 8 bytes. Without it,
// any payload is accepted, trailing 1-3 bytes are dropped, and a payload of
// fewer than 4 bytes produces no word.
module alu_pkt_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [DATA_WIDTH-1:0]   rx_data_i,
    input  logic                    rx_valid_i,
    output logic                    rx_ready_o,
    output logic [4*DATA_WIDTH-1:0] word_o,
    output logic                    word_valid_o,
    input  logic                    word_ready_i,
    output logic [1:0]              op_o,
    output logic                    word_first_o,
    output logic                    word_last_o,
    output logic [DATA_WIDTH-1:0]   echo_data_o,
    output logic                    echo_valid_o,
    input  logic                    echo_ready_i,
    output logic                    err_o
);

    typedef enum logic [2:0] {
        S_OPCODE, S_RESERVED, S_LEN_LSB, S_LEN_MSB,
        S_ECHO, S_COLLECT, S_EMIT, S_DISCARD
    } state_e;

    typedef enum logic [2:0] {
        K_ECHO, K_ADD, K_MUL, K_DIV, K_BAD
    } kind_e;

    function automatic kind_e decode(input logic [DATA_WIDTH-1:0] b);
        case (b)
            DATA_WIDTH'(8'hEC): decode = K_ECHO;
            DATA_WIDTH'(8'hAD): decode = K_ADD;
            DATA_WIDTH'(8'h88): decode = K_MUL;
            DATA_WIDTH'(8'hD1): decode = K_DIV;
            default:            decode = K_BAD;
        endcase
    endfunction

    state_e                  state_q, state_d;
    kind_e                   kind_q;
    logic [7:0]              len_lsb_q;
    logic [15:0]             count_q;      // payload bytes still to arrive
    logic [1:0]              byte_idx_q;   // byte lane of the word being filled
    logic [4*DATA_WIDTH-1:0] word_q;
    logic                    first_q;
    logic                    err_q;
    logic                    err_set;
    logic                    accept;

    // Full packet length is only complete while the MSB is on the bus.
    logic [15:0] length;
    logic [15:0] payload_len;
    assign length      = {rx_data_i[7:0], len_lsb_q};
    assign payload_len = length - 16'd4;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= S_OPCODE;
        else         state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first; a path that
        // skips an assignment would otherwise infer a latch.
        state_d      = state_q;
        rx_ready_o   = 1'b1;
        echo_data_o  = rx_data_i;
        echo_valid_o = 1'b0;
        word_valid_o = 1'b0;
        err_set      = 1'b0;
        case (state_q)
            S_OPCODE:   if (rx_valid_i) state_d = S_RESERVED;
            S_RESERVED: if (rx_valid_i) state_d = S_LEN_LSB;
            S_LEN_LSB:  if (rx_valid_i) state_d = S_LEN_MSB;
            S_LEN_MSB: begin
                if (rx_valid_i) begin
                    if (length < 16'd4) begin
                        err_set = 1'b1;
                        state_d = S_OPCODE;
                    end else if (kind_q == K_ECHO) begin
                        state_d = (payload_len == 16'd0) ? S_OPCODE : S_ECHO;
                    end else if (kind_q == K_BAD) begin
                        err_set = 1'b1;
                        state_d = (payload_len == 16'd0) ? S_OPCODE : S_DISCARD;
`ifdef ALU_PKT_RX_CHKLEN_EN
                    end else if (payload_len[1:0] != 2'd0 || payload_len < 16'd8) begin
                        err_set = 1'b1;
                        state_d = (payload_len == 16'd0) ? S_OPCODE : S_DISCARD;
`endif
                    end else if (payload_len == 16'd0) begin
                        state_d = S_OPCODE;
                    end else if (payload_len < 16'd4) begin
                        state_d = S_DISCARD;   // too short for even one word
                    end else begin
                        state_d = S_COLLECT;
                    end
                end
            end
            S_ECHO: begin
                // Pass-through: the transmitter's ready paces the receiver.
                echo_valid_o = rx_valid_i;
                rx_ready_o   = echo_ready_i;
                if (rx_valid_i && echo_ready_i && count_q == 16'd1) state_d = S_OPCODE;
            end
            S_COLLECT: if (rx_valid_i && byte_idx_q == 2'd3) state_d = S_EMIT;
            S_EMIT: begin
                rx_ready_o   = 1'b0;
                word_valid_o = 1'b1;
                if (word_ready_i) begin
                    if (count_q == 16'd0)     state_d = S_OPCODE;
                    else if (count_q < 16'd4) state_d = S_DISCARD;  // partial tail
                    else                      state_d = S_COLLECT;
                end
            end
            S_DISCARD: if (rx_valid_i && count_q == 16'd1) state_d = S_OPCODE;
            default:   state_d = S_OPCODE;
        endcase
    end

    assign accept = rx_valid_i && rx_ready_o;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            kind_q     <= K_BAD;
            len_lsb_q  <= '0;
            count_q    <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            first_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            err_q <= err_set;
            case (state_q)
                S_OPCODE:  if (accept) kind_q <= decode(rx_data_i);
                S_LEN_LSB: if (accept) len_lsb_q <= rx_data_i[7:0];
                S_LEN_MSB: if (accept) begin
                    count_q    <= payload_len;
                    byte_idx_q <= '0;
                    first_q    <= 1'b1;
                end
                S_ECHO, S_DISCARD: if (accept) count_q <= count_q - 16'd1;
                S_COLLECT: if (accept) begin
                    word_q[int'(byte_idx_q)*DATA_WIDTH +: DATA_WIDTH] <= rx_data_i;
                    byte_idx_q <= byte_idx_q + 2'd1;
                    count_q    <= count_q - 16'd1;
                end
                S_EMIT: if (word_ready_i) first_q <= 1'b0;
                default: ;
            endcase
        end
    end

    always_comb begin
        op_o = 2'd0;
        case (kind_q)
            K_MUL:   op_o = 2'd1;
            K_DIV:   op_o = 2'd2;
            default: op_o = 2'd0;
        endcase
    end

    assign word_o       = word_q;
    // Fewer than 4 remaining bytes cannot form another word, so this one is last.
    assign word_first_o = (state_q == S_EMIT) && first_q;
    assign word_last_o  = (state_q == S_EMIT) && (count_q < 16'd4);
    assign err_o        = err_q;

endmodule
